reg_bank_sequencer: RTL and testbench
=====================================

Name: reg_bank_sequencer

Overview:
- Initiator-side controller for the 32x32 register bank: drives its write port (dr, wdata, write) and both read ports (sr1, sr2), and consumes regd1/regd2.
- On a start pulse it fills all registers with an arithmetic pattern, reads them back two per cycle, and reports pass/fail with an error count and the first failing address.
- Used as a power-on fill/self-check engine and as a synthesizable stimulus source for bank bring-up.

Parameters:
- DW, 32, data width of bank words
- AW, 5, address width; register count NREG = 2**AW (must be even)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  2  00 fill+check, 01 fill only, 10 check only, 11 treated as 00
- base  in  DW  pattern base value, latched on accepted start
- step  in  DW  pattern increment, latched on accepted start
- dr  out  AW  bank write address
- wdata  out  DW  bank write data
- write  out  1  bank write enable
- sr1  out  AW  bank read address, port 1
- sr2  out  AW  bank read address, port 2
- regd1  in  DW  bank read data for sr1 (combinational read, valid in the same cycle)
- regd2  in  DW  bank read data for sr2
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- pass  out  1  valid when done is high; 1 iff err_count == 0; held until the next start
- err_count  out  AW+1  number of mismatching registers, saturating at NREG
- first_err_addr  out  AW  address of the first mismatch; valid when err_count != 0

Behaviour:
- All outputs are registered. Reset values: dr=0, wdata=0, write=0, sr1=0, sr2=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, state=IDLE.
- Expected value: exp(i) = base_l + i*step_l, computed modulo 2^DW (truncate, wrap silently).
- States:
  - IDLE: start=1 latches base/step/mode and clears err_count/first_err_addr/pass. Next state is FILL (mode 00/01/11) or READ (mode 10). Counter cnt=0.
  - FILL: for exactly NREG cycles, write=1, dr=cnt, wdata=exp(cnt); cnt increments by 1 each cycle. After cnt=NREG-1, next state is READ (mode 00/11) or DONE (mode 01). write=0 in every other state.
  - READ: for exactly NREG/2 cycles, sr1=2k and sr2=2k+1, for k=0..NREG/2-1.
    - Compare happens on the edge ending each READ cycle: regd1 vs exp(2k), regd2 vs exp(2k+1).
    - err_count increments by the number of mismatches (0, 1 or 2), saturating.
    - first_err_addr loads on the first mismatch only. If both ports mismatch in the same cycle, the sr1 address wins.
  - DONE: one cycle; done=1, busy=0, pass=(final err_count==0). Next state is IDLE.
  - sr1/sr2 hold their last values outside READ.
- Latency, with start accepted at edge E0 (cycle n = the n-th cycle after E0):
  - mode 00: write high in cycles 1..NREG; reads in cycles NREG+1..NREG+NREG/2; done in cycle 3*NREG/2+1 (cycle 49 for NREG=32).
  - mode 01: done in cycle NREG+1.
  - mode 10: reads in cycles 1..NREG/2; done in cycle NREG/2+1.
- The last write lands at the edge leaving FILL, so the first READ cycle observes it.
- start while not IDLE (including DONE) is ignored; latched base/step/mode are unchanged.
- reset mid-operation: the next edge returns all outputs to reset values and write drops immediately. The partially filled bank contents are not restored.
- reset and start asserted together: reset wins.

Test Plan:
- Reset, then mode 00, base=0, step=10, against the real bank -> write pulses dr=0..31 with wdata=0,10,..,310. Reads show reg[30]=300 and reg[31]=310. done in cycle 49, pass=1, err_count=0.
- Same run, with the bench forcing regd2 bit0 inverted during read pair k=3 -> err_count=1, first_err_addr=7, pass=0.
- mode 01 with base=100, step=1, then mode 10 with base=100, step=1 -> pass=1, done in cycles 33 and 17 respectively. A second mode 10 run with base=200 -> err_count=32, first_err_addr=0.
- Wrap: base=32'hFFFF_FFF0, step=1 -> reg[16] written as 0 and reg[31]=15; check passes.
- start pulsed in cycles 5 and 48 of a mode 00 run -> both ignored; single done in cycle 49, base unchanged.
- reset asserted in FILL cycle 10 -> write=0 and busy=0 on the next edge; a fresh start then completes normally with pass=1.

Source files
------------

// File: rtl/reg_bank_sequencer_if.sv
// Bus between the fill/check sequencer and the 32x32 register bank.
// One write port (dr/wdata/write) and two combinational read ports (sr1/sr2 -> regd1/regd2).
interface reg_bank_sequencer_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5
) ();
   logic [AW-1:0] dr;
   logic [DW-1:0] wdata;
   logic          write;
   logic [AW-1:0] sr1;
   logic [AW-1:0] sr2;
   logic [DW-1:0] regd1;
   logic [DW-1:0] regd2;

   modport master (
      output dr, wdata, write, sr1, sr2,
      input  regd1, regd2
   );

   modport slave (
      input  dr, wdata, write, sr1, sr2,
      output regd1, regd2
   );
endinterface

// File: rtl/reg_bank_sequencer.sv
// Fill/self-check engine for the register bank: writes base + i*step to every register,
// reads them back two per cycle and reports pass, error count and first failing address.
module reg_bank_sequencer #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [DW-1:0]         base,
   input  logic [DW-1:0]         step,
   reg_bank_sequencer_if.master  bus,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [AW:0]           err_count,
   output logic [AW-1:0]         first_err_addr
);
   localparam int unsigned NREG = 2 ** AW;

   typedef enum logic [1:0] {StIdle, StFill, StRead, StDone} state_e;

   state_e        state;
   logic [DW-1:0] step_l;
   logic [DW-1:0] exp1;
   logic [DW-1:0] exp2;
   logic          check_after_fill;

   logic          mis1;
   logic          mis2;
   logic [AW+1:0] err_sum;
   logic [AW:0]   err_next;
   logic [AW-1:0] first_next;

   // Compare result for the current read pair; sr1 wins when both ports mismatch.
   always_comb begin
      mis1       = (bus.regd1 != exp1);
      mis2       = (bus.regd2 != exp2);
      err_sum    = {1'b0, err_count} + (AW+2)'(mis1) + (AW+2)'(mis2);
      err_next   = (err_sum > (AW+2)'(NREG)) ? (AW+1)'(NREG) : err_sum[AW:0];
      first_next = first_err_addr;
      if (err_count == '0) begin
         if (mis1) begin
            first_next = bus.sr1;
         end else if (mis2) begin
            first_next = bus.sr2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= StIdle;
         step_l           <= '0;
         exp1             <= '0;
         exp2             <= '0;
         check_after_fill <= 1'b0;
         bus.dr           <= '0;
         bus.wdata        <= '0;
         bus.write        <= 1'b0;
         bus.sr1          <= '0;
         bus.sr2          <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_err_addr   <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  step_l           <= step;
                  exp1             <= base;
                  exp2             <= base + step;
                  check_after_fill <= (mode != 2'b01);
                  err_count        <= '0;
                  first_err_addr   <= '0;
                  pass             <= 1'b0;
                  busy             <= 1'b1;
                  if (mode == 2'b10) begin
                     state   <= StRead;
                     bus.sr1 <= '0;
                     bus.sr2 <= AW'(1);
                  end else begin
                     state     <= StFill;
                     bus.write <= 1'b1;
                     bus.dr    <= '0;
                     bus.wdata <= base;
                  end
               end
            end
            StFill: begin
               if (bus.dr == AW'(NREG - 1)) begin
                  bus.write <= 1'b0;
                  if (check_after_fill) begin
                     state   <= StRead;
                     bus.sr1 <= '0;
                     bus.sr2 <= AW'(1);
                  end else begin
                     state <= StDone;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     pass  <= (err_count == '0);
                  end
               end else begin
                  bus.dr    <= bus.dr + AW'(1);
                  bus.wdata <= bus.wdata + step_l;
               end
            end
            StRead: begin
               err_count      <= err_next;
               first_err_addr <= first_next;
               exp1           <= exp1 + (step_l << 1);
               exp2           <= exp2 + (step_l << 1);
               if (bus.sr1 == AW'(NREG - 2)) begin
                  state <= StDone;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  pass  <= (err_next == '0);
               end else begin
                  bus.sr1 <= bus.sr1 + AW'(2);
                  bus.sr2 <= bus.sr2 + AW'(2);
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Bench for reg_bank_sequencer: behavioural bank plus a per-run model of expected traffic,
// done timing and error report, with directed and randomized runs.
module tb_reg_bank_sequencer;
   localparam int NREG = 32;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  mode;
   logic [31:0] base;
   logic [31:0] step;
   logic        busy;
   logic        done;
   logic        pass;
   logic [5:0]  err_count;
   logic [4:0]  first_err_addr;

   int          tests;
   int          fails;
   int          cor_addr;
   logic [31:0] cor_mask;
   logic [31:0] bank [NREG];

   reg_bank_sequencer_if #(.DW(32), .AW(5)) bus ();

   reg_bank_sequencer #(.DW(32), .AW(5)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .mode           (mode),
      .base           (base),
      .step           (step),
      .bus            (bus),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register bank with optional corruption of one address on the read side.
   always_ff @(posedge clk) begin
      if (bus.write) bank[bus.dr] <= bus.wdata;
   end
   assign bus.regd1 = bank[bus.sr1] ^ ((int'(bus.sr1) == cor_addr) ? cor_mask : 32'h0);
   assign bus.regd2 = bank[bus.sr2] ^ ((int'(bus.sr2) == cor_addr) ? cor_mask : 32'h0);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_dr"}, 64'(bus.dr), 0);
      chk({tag, "_wdata"}, 64'(bus.wdata), 0);
      chk({tag, "_write"}, 64'(bus.write), 0);
      chk({tag, "_sr1"}, 64'(bus.sr1), 0);
      chk({tag, "_sr2"}, 64'(bus.sr2), 0);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_done"}, 64'(done), 0);
      chk({tag, "_pass"}, 64'(pass), 0);
      chk({tag, "_err"}, 64'(err_count), 0);
      chk({tag, "_first"}, 64'(first_err_addr), 0);
   endtask

   // One complete operation; poke pulses stray starts in cycles 5 and 48.
   task automatic run(input logic [1:0] md, input logic [31:0] b, input logic [31:0] s,
                      input bit poke);
      logic [31:0] expv [NREG];
      logic [31:0] seen [NREG];
      bit          fills;
      bit          reads;
      int          exp_done, r0, exp_err, exp_first;
      int          wr_cnt, bad_wr, bad_rd, bad_busy, ndone, done_cyc;
      logic        got_pass;
      logic [5:0]  got_err;
      logic [4:0]  got_first;

      fills     = (md != 2'b10);
      reads     = (md != 2'b01);
      exp_done  = fills ? (reads ? 3 * NREG / 2 + 1 : NREG + 1) : NREG / 2 + 1;
      r0        = fills ? NREG + 1 : 1;
      exp_err   = 0;
      exp_first = 0;
      for (int i = 0; i < NREG; i++) begin
         expv[i] = b + s * 32'(i);
         seen[i] = fills ? expv[i] : bank[i];
         if (i == cor_addr) seen[i] ^= cor_mask;
         if (reads && seen[i] !== expv[i]) begin
            if (exp_err == 0) exp_first = i;
            exp_err++;
         end
      end

      wr_cnt = 0; bad_wr = 0; bad_rd = 0; bad_busy = 0; ndone = 0; done_cyc = -1;
      got_pass = 1'bx; got_err = 'x; got_first = 'x;
      mode = md; base = b; step = s; start = 1'b1;
      for (int n = 1; n <= exp_done + 2; n++) begin
         @(posedge clk); #1;
         start = poke && (n == 5 || n == 48);
         mode  = 2'($urandom_range(0, 3));
         base  = $urandom;
         step  = $urandom;
         if (bus.write === 1'b1) begin
            if (!fills || n > NREG || bus.dr !== 5'(n - 1) || bus.wdata !== expv[n - 1])
               bad_wr++;
            wr_cnt++;
         end
         if (reads && n >= r0 && n < r0 + NREG / 2) begin
            if (bus.sr1 !== 5'(2 * (n - r0)) || bus.sr2 !== 5'(2 * (n - r0) + 1)) bad_rd++;
         end
         if (busy !== 1'(n < exp_done)) bad_busy++;
         if (done === 1'b1) begin
            ndone++;
            done_cyc  = n;
            got_pass  = pass;
            got_err   = err_count;
            got_first = first_err_addr;
         end
      end
      start = 1'b0;

      chk("write_count", 64'(wr_cnt), fills ? NREG : 0);
      chk("write_data", 64'(bad_wr), 0);
      chk("read_addr", 64'(bad_rd), 0);
      chk("busy", 64'(bad_busy), 0);
      chk("done_count", 64'(ndone), 1);
      chk("done_cycle", 64'(done_cyc), 64'(exp_done));
      chk("pass", 64'(got_pass), 64'(exp_err == 0));
      chk("err_count", 64'(got_err), 64'(exp_err));
      if (exp_err != 0) chk("first_err_addr", 64'(got_first), 64'(exp_first));
      chk("pass_held", 64'(pass), 64'(exp_err == 0));
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      cor_addr = -1;
      cor_mask = 32'h0;
      reset    = 1'b1;
      start    = 1'b0;
      mode     = 2'b00;
      base     = 32'h0;
      step     = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      reset = 1'b0;

      run(2'b00, 32'd0, 32'd10, 1'b0);
      chk("bank30", 64'(bank[30]), 300);
      chk("bank31", 64'(bank[31]), 310);

      cor_addr = 7;
      cor_mask = 32'h1;
      run(2'b00, 32'd0, 32'd10, 1'b0);
      cor_addr = -1;

      run(2'b01, 32'd100, 32'd1, 1'b0);
      run(2'b10, 32'd100, 32'd1, 1'b0);
      run(2'b10, 32'd200, 32'd1, 1'b0);

      run(2'b00, 32'hFFFF_FFF0, 32'd1, 1'b0);
      chk("wrap_bank16", 64'(bank[16]), 0);
      chk("wrap_bank31", 64'(bank[31]), 15);

      run(2'b00, 32'd5, 32'd3, 1'b1);

      // Reset in FILL cycle 10.
      start = 1'b1; mode = 2'b00; base = 32'd1; step = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("fill_write_c10", 64'(bus.write), 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk_reset_state("midreset");
      start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      chk("rst_start_busy", 64'(busy), 0);
      chk("rst_start_write", 64'(bus.write), 0);
      run(2'b00, $urandom, $urandom, 1'b0);

      for (int r = 0; r < 6; r++) begin
         cor_addr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NREG - 1)) : -1;
         cor_mask = $urandom | 32'h1;
         run(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
      end
      cor_addr = -1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
